// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle between the CPU requesters, the arbiter and the memory bridge.
// The master modport is the arbiter's view; slave is the CPU/bridge side.
interface sram_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// One transaction in flight; data wins contention until inst has starved STARVE_LIMIT times.
module sram_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  sram_bus_arbiter_if.master  bus
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  state_e        state;
  owner_e        owner;
  logic [CW-1:0] starve_cnt;

  logic          mem_req_q;
  logic          mem_wr_q;
  logic [1:0]    mem_size_q;
  logic [3:0]    mem_wstrb_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   inst_rdata_q;
  logic [31:0]   data_rdata_q;

  logic          starved;
  logic          grant_data;
  logic          grant_inst;
  logic          rsp_valid;

  // Grants and responses are gated by reset so an abandoned transaction never answers.
  always_comb begin
    starved    = bus.inst_req && (starve_cnt == LIMIT);
    grant_data = (state == IDLE) && !reset && bus.data_req && !starved;
    grant_inst = (state == IDLE) && !reset && bus.inst_req && !grant_data;
    rsp_valid  = (state == WAIT) && !reset && bus.mem_data_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= OWN_INST;
      starve_cnt   <= '0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_size_q   <= '0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_data) begin
            owner       <= OWN_DATA;
            mem_req_q   <= 1'b1;
            mem_wr_q    <= bus.data_wr;
            mem_size_q  <= bus.data_size;
            mem_wstrb_q <= bus.data_wr ? bus.data_wstrb : '0;
            mem_addr_q  <= bus.data_addr;
            mem_wdata_q <= bus.data_wdata;
            state       <= ISSUE;
            if (!bus.inst_req)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + CW'(1);
          end else if (grant_inst) begin
            owner       <= OWN_INST;
            mem_req_q   <= 1'b1;
            mem_wr_q    <= 1'b0;
            mem_size_q  <= 2'd2;
            mem_wstrb_q <= '0;
            mem_addr_q  <= bus.inst_addr;
            mem_wdata_q <= '0;
            starve_cnt  <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_addr_ok) begin
            mem_req_q <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_data_ok) begin
            if (owner == OWN_DATA)
              data_rdata_q <= bus.mem_rdata;
            else
              inst_rdata_q <= bus.mem_rdata;
            state <= IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.inst_addr_ok = grant_inst;
  assign bus.data_addr_ok = grant_data;

  // Response data passes straight through on the data_ok cycle, then the captured copy holds.
  assign bus.inst_data_ok = rsp_valid && (owner == OWN_INST);
  assign bus.data_data_ok = rsp_valid && (owner == OWN_DATA);
  assign bus.inst_rdata   = bus.inst_data_ok ? bus.mem_rdata : inst_rdata_q;
  assign bus.data_rdata   = bus.data_data_ok ? bus.mem_rdata : data_rdata_q;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed and randomized checks of sram_bus_arbiter against a protocol-level model.
module tb_sram_bus_arbiter;

  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_bus_arbiter_if bus();

  sram_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    bit          own_data;
    logic        wr;
    logic [1:0]  sz;
    logic [3:0]  stb;
    logic [31:0] a;
    logic [31:0] wd;
  } txn_t;

  // Model: phase 0 = free, 1 = request on memory port, 2 = awaiting response.
  int unsigned ph = 0;
  int unsigned streak = 0;
  bit          ipend = 0, dpend = 0;
  logic [31:0] ia, da, dwd;
  logic        dwr;
  logic [1:0]  dsz;
  logic [3:0]  dstb;
  txn_t        cur;
  string       glog = "";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},    bus.mem_req, 0);
    chk({tag, "_mem_wr"},     bus.mem_wr, 0);
    chk({tag, "_mem_size"},   bus.mem_size, 0);
    chk({tag, "_mem_wstrb"},  bus.mem_wstrb, 0);
    chk({tag, "_mem_addr"},   bus.mem_addr, 0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata, 0);
    chk({tag, "_i_addr_ok"},  bus.inst_addr_ok, 0);
    chk({tag, "_d_addr_ok"},  bus.data_addr_ok, 0);
    chk({tag, "_i_data_ok"},  bus.inst_data_ok, 0);
    chk({tag, "_d_data_ok"},  bus.data_data_ok, 0);
    chk({tag, "_i_rdata"},    bus.inst_rdata, 0);
    chk({tag, "_d_rdata"},    bus.data_rdata, 0);
  endtask

  task automatic clear_inputs();
    bus.inst_req = 0; bus.inst_addr = '0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = '0; bus.data_wstrb = '0;
    bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;
  endtask

  // Randomized traffic; percentages control request, accept and response rates.
  task automatic run(input int unsigned n, input int unsigned preq,
                     input int unsigned pack, input int unsigned pdok);
    bit gd, gi, eio, edo;
    for (int unsigned c = 0; c < n; c++) begin
      if (!ipend && $urandom_range(99) < preq) begin
        ipend = 1; ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!dpend && $urandom_range(99) < preq) begin
        dpend = 1; dwr = 1'($urandom_range(1)); dsz = 2'($urandom_range(2));
        dstb = 4'($urandom); da = $urandom; dwd = $urandom;
      end
      bus.inst_req = ipend; bus.inst_addr = ia;
      bus.data_req = dpend; bus.data_wr = dwr; bus.data_size = dsz;
      bus.data_wstrb = dstb; bus.data_addr = da; bus.data_wdata = dwd;
      bus.mem_addr_ok = ($urandom_range(99) < pack);
      bus.mem_data_ok = ($urandom_range(99) < pdok);
      bus.mem_rdata   = $urandom;
      #1;
      gd = (ph == 0) && dpend && !(ipend && streak == LIMIT);
      gi = (ph == 0) && ipend && !gd;
      eio = (ph == 2) && bus.mem_data_ok && !cur.own_data;
      edo = (ph == 2) && bus.mem_data_ok && cur.own_data;
      chk("r_inst_addr_ok", bus.inst_addr_ok, gi);
      chk("r_data_addr_ok", bus.data_addr_ok, gd);
      chk("r_mem_req", bus.mem_req, ph == 1);
      chk("r_inst_data_ok", bus.inst_data_ok, eio);
      chk("r_data_data_ok", bus.data_data_ok, edo);
      if (eio) chk("r_inst_rdata", bus.inst_rdata, bus.mem_rdata);
      if (edo) chk("r_data_rdata", bus.data_rdata, bus.mem_rdata);
      if (ph == 1) begin
        chk("r_mem_wr", bus.mem_wr, cur.wr);
        chk("r_mem_size", bus.mem_size, cur.sz);
        chk("r_mem_wstrb", bus.mem_wstrb, cur.stb);
        chk("r_mem_addr", bus.mem_addr, cur.a);
        chk("r_mem_wdata", bus.mem_wdata, cur.wd);
      end
      case (ph)
        0: begin
          if (gd) begin
            cur = '{1'b1, dwr, dsz, dwr ? dstb : 4'h0, da, dwd};
            streak = ipend ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
            dpend = 0; glog = {glog, "D"}; ph = 1;
          end else if (gi) begin
            cur = '{1'b0, 1'b0, 2'd2, 4'h0, ia, 32'h0};
            streak = 0; ipend = 0; glog = {glog, "I"}; ph = 1;
          end
        end
        1: if (bus.mem_addr_ok) ph = 2;
        default: if (bus.mem_data_ok) ph = 0;
      endcase
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk_all_zero("rst");
    tick();

    // Single fetch with immediate memory handshakes.
    bus.inst_req = 1; bus.inst_addr = 32'h1C00_0000;
    bus.mem_addr_ok = 1; bus.mem_data_ok = 1; bus.mem_rdata = 32'h0280_0C0C;
    #1;
    chk("t1_inst_addr_ok", bus.inst_addr_ok, 1);
    chk("t1_data_addr_ok", bus.data_addr_ok, 0);
    chk("t1_mem_req_c0", bus.mem_req, 0);
    tick();
    bus.inst_req = 0;
    #1;
    chk("t1_mem_req_c1", bus.mem_req, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h1C00_0000);
    chk("t1_mem_wr", bus.mem_wr, 0);
    chk("t1_mem_size", bus.mem_size, 2);
    chk("t1_mem_wstrb", bus.mem_wstrb, 0);
    chk("t1_early_data_ok", bus.inst_data_ok, 0);
    tick();
    #1;
    chk("t1_inst_data_ok", bus.inst_data_ok, 1);
    chk("t1_inst_rdata", bus.inst_rdata, 32'h0280_0C0C);
    chk("t1_data_data_ok", bus.data_data_ok, 0);
    chk("t1_mem_req_c2", bus.mem_req, 0);
    tick();
    // Spurious memory handshakes while idle.
    bus.mem_rdata = 32'h1111_2222;
    #1;
    chk("t5_inst_data_ok", bus.inst_data_ok, 0);
    chk("t5_data_data_ok", bus.data_data_ok, 0);
    chk("t5_inst_rdata_held", bus.inst_rdata, 32'h0280_0C0C);
    tick();
    #1;
    chk("t5_mem_req", bus.mem_req, 0);
    chk("t5_inst_data_ok2", bus.inst_data_ok, 0);
    tick();

    // Byte store.
    bus.mem_addr_ok = 1; bus.mem_data_ok = 0;
    bus.data_req = 1; bus.data_wr = 1; bus.data_size = 0; bus.data_wstrb = 4'b0100;
    bus.data_addr = 32'h0000_1002; bus.data_wdata = 32'h00AB_0000;
    #1;
    chk("t2_data_addr_ok", bus.data_addr_ok, 1);
    chk("t2_inst_addr_ok", bus.inst_addr_ok, 0);
    tick();
    bus.data_req = 0;
    #1;
    chk("t2_mem_req", bus.mem_req, 1);
    chk("t2_mem_wr", bus.mem_wr, 1);
    chk("t2_mem_size", bus.mem_size, 0);
    chk("t2_mem_wstrb", bus.mem_wstrb, 4'b0100);
    chk("t2_mem_addr", bus.mem_addr, 32'h0000_1002);
    chk("t2_mem_wdata", bus.mem_wdata, 32'h00AB_0000);
    tick();
    bus.mem_addr_ok = 0;
    #1;
    chk("t2_mem_req_wait", bus.mem_req, 0);
    chk("t2_no_data_ok_yet", bus.data_data_ok, 0);
    bus.mem_data_ok = 1;
    #1;
    chk("t2_data_data_ok", bus.data_data_ok, 1);
    chk("t2_inst_data_ok", bus.inst_data_ok, 0);
    tick();
    bus.mem_data_ok = 0;
    #1;
    chk("t2_data_ok_once", bus.data_data_ok, 0);
    tick();

    // Load with memory back-pressure; loads must drop the write strobe.
    bus.data_req = 1; bus.data_wr = 0; bus.data_size = 2; bus.data_wstrb = 4'hF;
    bus.data_addr = 32'h0000_2000; bus.data_wdata = 32'h1234_5678;
    #1;
    chk("t4_data_addr_ok", bus.data_addr_ok, 1);
    tick();
    bus.inst_req = 1; bus.inst_addr = 32'h1C00_0040;
    bus.data_addr = 32'h0000_3000; bus.data_wdata = 32'h8765_4321;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_mem_req", bus.mem_req, 1);
      chk("t4_mem_addr", bus.mem_addr, 32'h0000_2000);
      chk("t4_mem_wstrb", bus.mem_wstrb, 0);
      chk("t4_mem_wr", bus.mem_wr, 0);
      chk("t4_mem_wdata", bus.mem_wdata, 32'h1234_5678);
      chk("t4_inst_addr_ok", bus.inst_addr_ok, 0);
      chk("t4_data_addr_ok", bus.data_addr_ok, 0);
      tick();
    end
    bus.inst_req = 0; bus.data_req = 0; bus.mem_addr_ok = 1;
    #1;
    chk("t4_mem_req_acc", bus.mem_req, 1);
    tick();
    bus.mem_addr_ok = 0; bus.mem_data_ok = 1; bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("t4_data_data_ok", bus.data_data_ok, 1);
    chk("t4_data_rdata", bus.data_rdata, 32'hCAFE_F00D);
    chk("t4_inst_data_ok", bus.inst_data_ok, 0);
    tick();
    bus.mem_data_ok = 0;
    #1;
    chk("t4_data_rdata_held", bus.data_rdata, 32'hCAFE_F00D);
    chk("t4_data_ok_done", bus.data_data_ok, 0);
    tick();

    // Build a data streak, then reset in the middle of a transaction.
    run(7, 100, 100, 100);
    bus.mem_addr_ok = 1; bus.mem_data_ok = 0;
    #1;
    chk("t6_mem_req", bus.mem_req, 1);
    tick();
    clear_inputs();
    reset = 1; bus.mem_data_ok = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t6_inst_data_ok", bus.inst_data_ok, 0);
    chk("t6_data_data_ok", bus.data_data_ok, 0);
    tick();
    reset = 0; bus.mem_data_ok = 0;
    #1;
    chk_all_zero("t6");
    ph = 0; streak = 0; ipend = 0; dpend = 0; glog = "";

    // Sustained contention from a cleared starvation counter.
    run(40, 100, 100, 100);
    checks++;
    assert (glog.substr(0, 9) == "DDDDIDDDDI") else begin
      errors++;
      $error("FAIL grant_order got=%s exp=DDDDIDDDDI", glog);
    end

    run(1500, 50, 60, 50);
    run(500, 90, 30, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
